fir_filter: RTL and testbench



---
 rtl/fir_filter_pkg.sv | 9 +
 rtl/fir_filter.sv | 70 +++++++
 tb/tb_fir_filter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fir_filter_pkg.sv
// Shared helpers for the polyphase FIR branches.
package fir_filter_pkg;

    // Accumulator growth bits for an n-tap sum; zero for one or two taps.
    function automatic int unsigned fir_growth_bits(input int unsigned n);
        return (n <= 2) ? 0 : $clog2(n - 1);
    endfunction

endpackage

// File: rtl/fir_filter.sv
// Direct-form valid-gated FIR: registered tap delay line, combinational MAC,
// one output register with a single-cycle valid strobe.
module fir_filter
    import fir_filter_pkg::*;
#(
    parameter int INPUT_WORD_SIZE = 16,
    parameter int COEFF_WORD_SIZE = 16,
    parameter int N_COEFFS        = 20,
    localparam int OUTPUT_WORD_SIZE = INPUT_WORD_SIZE + COEFF_WORD_SIZE
                                      + int'(fir_growth_bits(N_COEFFS))
) (
    input  logic                                             clk,
    input  logic                                             arst_n,
    input  logic [N_COEFFS-1:0][COEFF_WORD_SIZE-1:0]         coeff,
    input  logic signed [INPUT_WORD_SIZE-1:0]                data_in,
    input  logic                                             valid_in,
    output logic signed [OUTPUT_WORD_SIZE-1:0]               data_out,
    output logic                                             valid_out
);

    localparam int PROD_W = INPUT_WORD_SIZE + COEFF_WORD_SIZE;

    logic signed [INPUT_WORD_SIZE-1:0]  x_q [N_COEFFS];
    logic signed [INPUT_WORD_SIZE-1:0]  x_d [N_COEFFS];
    logic signed [OUTPUT_WORD_SIZE-1:0] data_out_q, data_out_d;
    logic                               valid_out_q, valid_out_d;
    logic signed [OUTPUT_WORD_SIZE-1:0] acc;
    logic signed [PROD_W-1:0]           prod;
    logic signed [OUTPUT_WORD_SIZE-1:0] prod_ext;

    // The MAC sees the shifted line so the new sample lands on coeff[0].
    always_comb begin
        x_d         = x_q;
        data_out_d  = data_out_q;
        valid_out_d = valid_in;
        acc         = '0;
        prod        = '0;
        prod_ext    = '0;
        if (valid_in) begin
            x_d[0] = data_in;
            for (int unsigned k = 1; k < N_COEFFS; k++) begin
                x_d[k] = x_q[k-1];
            end
        end
        for (int unsigned k = 0; k < N_COEFFS; k++) begin
            prod     = $signed(coeff[k]) * x_d[k];
            prod_ext = prod;
            acc      = acc + prod_ext;
        end
        if (valid_in) begin
            data_out_d = acc;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            x_q         <= '{default: '0};
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
        end else begin
            x_q         <= x_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign data_out  = data_out_q;
    assign valid_out = valid_out_q;

endmodule

// File: tb/tb_fir_filter.sv
// Directed and randomized checks of fir_filter at 4, 2 and 20 taps.
module tb_fir_filter;

    localparam int OW4  = 34;
    localparam int OW2  = 32;
    localparam int OW20 = 37;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0][15:0]        c4  = '0;
    logic signed [15:0]      d4  = '0;
    logic                    v4  = 1'b0;
    logic signed [OW4-1:0]   o4;
    logic                    ov4;

    logic [1:0][15:0]        c2  = '0;
    logic signed [15:0]      d2  = '0;
    logic                    v2  = 1'b0;
    logic signed [OW2-1:0]   o2;
    logic                    ov2;

    logic [19:0][15:0]       c20 = '0;
    logic signed [15:0]      d20 = '0;
    logic                    v20 = 1'b0;
    logic signed [OW20-1:0]  o20;
    logic                    ov20;

    fir_filter #(.INPUT_WORD_SIZE(16), .COEFF_WORD_SIZE(16), .N_COEFFS(4)) dut4 (
        .clk(clk), .arst_n(arst_n), .coeff(c4), .data_in(d4), .valid_in(v4),
        .data_out(o4), .valid_out(ov4));

    fir_filter #(.INPUT_WORD_SIZE(16), .COEFF_WORD_SIZE(16), .N_COEFFS(2)) dut2 (
        .clk(clk), .arst_n(arst_n), .coeff(c2), .data_in(d2), .valid_in(v2),
        .data_out(o2), .valid_out(ov2));

    fir_filter #(.INPUT_WORD_SIZE(16), .COEFF_WORD_SIZE(16), .N_COEFFS(20)) dut20 (
        .clk(clk), .arst_n(arst_n), .coeff(c20), .data_in(d20), .valid_in(v20),
        .data_out(o20), .valid_out(ov20));

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step4(input logic signed [15:0] d, input logic v);
        d4 = d;
        v4 = v;
        @(posedge clk);
        #1;
    endtask

    logic signed [15:0] hist [20];
    longint exp20;
    longint s;
    logic   v;

    initial begin
        // Reset state of every instance
        #12;
        check_eq("rst_o4",  longint'(o4), 0);
        check_eq("rst_v4",  longint'(ov4), 0);
        check_eq("rst_o2",  longint'(o2), 0);
        check_eq("rst_v2",  longint'(ov2), 0);
        check_eq("rst_o20", longint'(o20), 0);
        check_eq("rst_v20", longint'(ov20), 0);
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        // Impulse response, taps {1,2,3,4}
        c4[0] = 16'd1; c4[1] = 16'd2; c4[2] = 16'd3; c4[3] = 16'd4;
        step4(16'sd1, 1'b1);
        check_eq("imp_v0", longint'(ov4), 1); check_eq("imp_o0", longint'(o4), 1);
        step4(16'sd0, 1'b1);
        check_eq("imp_v1", longint'(ov4), 1); check_eq("imp_o1", longint'(o4), 2);
        step4(16'sd0, 1'b1);
        check_eq("imp_v2", longint'(ov4), 1); check_eq("imp_o2", longint'(o4), 3);
        step4(16'sd0, 1'b1);
        check_eq("imp_v3", longint'(ov4), 1); check_eq("imp_o3", longint'(o4), 4);
        step4(16'sd0, 1'b1);
        check_eq("imp_v4", longint'(ov4), 1); check_eq("imp_o4", longint'(o4), 0);
        step4(16'sd0, 1'b0);
        check_eq("imp_v5", longint'(ov4), 0);

        // Sparse valid: 5, three idle cycles, then 0
        step4(16'sd5, 1'b1);
        check_eq("sp_v0", longint'(ov4), 1); check_eq("sp_o0", longint'(o4), 5);
        for (int i = 0; i < 3; i++) begin
            step4(16'sd9, 1'b0);
            check_eq("sp_idle_v", longint'(ov4), 0);
            check_eq("sp_idle_o", longint'(o4), 5);
        end
        step4(16'sd0, 1'b1);
        check_eq("sp_v1", longint'(ov4), 1); check_eq("sp_o1", longint'(o4), 10);

        // Mid-stream asynchronous reset clears history
        step4(16'sd3, 1'b1);
        step4(16'sd4, 1'b1);
        step4(16'sd5, 1'b1);
        check_eq("pre_rst_o", longint'(o4), 5*1 + 4*2 + 3*3 + 0*4);
        v4 = 1'b0;
        #2;
        arst_n = 1'b0;
        #1;
        check_eq("mid_rst_o", longint'(o4), 0);
        check_eq("mid_rst_v", longint'(ov4), 0);
        #2;
        arst_n = 1'b1;
        c4 = {4{16'd1}};
        @(posedge clk);
        #1;
        step4(16'sd7, 1'b1);
        check_eq("post_rst_v", longint'(ov4), 1);
        check_eq("post_rst_o", longint'(o4), 7);
        step4(16'sd0, 1'b0);

        // Signed extremes with 32-bit wrap
        c2[0] = 16'h8000; c2[1] = 16'h8000;
        d2 = -16'sd32768; v2 = 1'b1;
        @(posedge clk); #1;
        check_eq("ext_o0", longint'(o2), 64'sd1073741824);
        @(posedge clk); #1;
        check_eq("ext_o1", longint'(o2), -64'sd2147483648);
        v2 = 1'b0;

        // Random regression against a golden convolution
        foreach (hist[k]) hist[k] = '0;
        exp20 = 0;
        for (int k = 0; k < 20; k++) c20[k] = 16'($urandom);
        for (int cyc = 0; cyc < 400; cyc++) begin
            v = ($urandom_range(0, 1) == 1);
            if (cyc % 40 == 39) begin
                // Coefficient change on an idle cycle must not disturb data_out.
                for (int k = 0; k < 20; k++) c20[k] = 16'($urandom);
                v = 1'b0;
            end
            d20 = 16'($urandom);
            v20 = v;
            if (v) begin
                for (int k = 19; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = d20;
                s = 0;
                for (int k = 0; k < 20; k++) s += longint'($signed(c20[k])) * longint'(hist[k]);
                exp20 = s;
            end
            @(posedge clk);
            #1;
            check_eq("rnd_v", longint'(ov20), longint'(v));
            check_eq("rnd_o", longint'(o20), exp20);
        end
        v20 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
